led_pulse_drv: RTL and testbench
================================

Name: led_pulse_drv

Overview:
- Human-facing output counterpart of the debounced button path. The debouncer turns a noisy human input into a clean internal signal; this block turns internal single-cycle events into LED blinks a human can see.
- Counts event rising edges into a pending count and plays one LED blink per event, each with a guaranteed minimum on-time and off-time.
- Sits between core logic (instruction retire, error, button acknowledge) and the board LED pins, all on clk_100MHz.

Parameters:
- ON_CYCLES, 5000000, LED-high duration per blink in clocks (50 ms at 100 MHz); must be >= 1.
- OFF_CYCLES, 5000000, minimum LED-low gap after each blink in clocks; must be >= 1.
- CNT_W, 8, width of the pending-event counter; saturates at 2^CNT_W-1.

Ports:
- clk_100MHz  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- evt_in  input  1  event request; each 0->1 transition is one event.
- LED_Out  output  1  registered LED drive, 1 = lit.
- busy  output  1  registered; 1 while state is ON or OFF.
- pending  output  CNT_W  events accepted but not yet started.
- overflow  output  1  sticky; set when an edge arrives while pending is saturated.

Behaviour:
- Reset: rst_n sampled low at a clock edge gives the following after that edge: state=IDLE, LED_Out=0, busy=0, pending=0, overflow=0, timer=0, evt_prev=0. Reset mid-blink aborts immediately with no completion of on or off time.
- Edge detect:
  - edge = evt_in & ~evt_prev; evt_prev registers evt_in every cycle.
  - A level held high counts as exactly one event.
  - The first cycle out of reset with evt_in=1 counts as an edge.
- Pending counter, updated each edge:
  - +1 if edge and not saturated.
  - -1 if the FSM starts a blink.
  - Both in the same cycle: unchanged.
  - Edge while saturated and no start: value held, overflow<=1.
- FSM, states IDLE, ON, OFF:
  - IDLE: if pending != 0, go to ON, pending -1, timer<=ON_CYCLES-1, LED_Out<=1. An edge arriving in the same cycle only increments pending; it does not start a blink that cycle.
  - ON: if timer != 0, timer -1; else go to OFF, timer<=OFF_CYCLES-1, LED_Out<=0.
  - OFF: if timer != 0, timer -1. Else, if pending != 0, go directly to ON (load and decrement as in IDLE). Otherwise go to IDLE.
- Timing, for an edge sampled at clock edge k with the FSM in IDLE:
  - pending=1 after edge k.
  - LED_Out=1 after edges k+1 .. k+ON_CYCLES, i.e. exactly ON_CYCLES cycles.
  - LED_Out=0 for exactly OFF_CYCLES cycles.
  - Back-to-back blink period is ON_CYCLES+OFF_CYCLES.
- Width rules:
  - Timer width = $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
  - Pending width is CNT_W, with saturating arithmetic and no wrap.
- Outputs:
  - busy = (state != IDLE), registered alongside state.
  - All outputs come straight from flops; no combinational paths from input to output.

Optional Feature:
- Macro LED_PULSE_SYNC_IN_EN.
- Defined: evt_in passes through a 2-flop synchronizer (reset to 0) before edge detection. Async sources are legal. Every latency above grows by 2 cycles.
- Undefined: evt_in must be synchronous to clk_100MHz; no extra latency.

Decomposition:
- Shared package led_drv_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ON=2'd1, ST_OFF=2'd2.
  - default timing constants LED_ON_50MS, LED_OFF_50MS.
- One natural sub-module, evt_edge_det. It holds the optional synchronizer plus the rising-edge detect and outputs a single-cycle edge strobe.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, CNT_W=2):
- Single 1-cycle pulse sampled at edge 10 -> pending=1 after edge 10; LED_Out=1 after edges 11..14 and 0 after edges 15..17; busy 1 after edges 11..17; IDLE after edge 18.
- Three 1-cycle pulses at edges 10,12,14 -> three blinks with period 7 and no IDLE gap between them; pending sequence 1,0,1,1,2 then decrements as blinks start; overflow stays 0.
- evt_in held high for 20 cycles -> exactly one blink; pending never exceeds 1.
- Five edges while busy -> pending saturates at 3, overflow=1 and stays 1 after all blinks drain (3 extra blinks after the current one).
- Edge coinciding with an OFF->ON restart -> pending unchanged that cycle (increment and decrement cancel).
- rst_n low for one cycle during ON -> after that edge LED_Out=0, busy=0, pending=0, overflow=0; the next edge starts cleanly with 2-cycle latency.

Source files
------------

// File: rtl/led_drv_pkg.sv
// ============================================================================
// led_drv_pkg: shared state encoding and default timing for led_pulse_drv.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_drv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  // 50 ms at 100 MHz
  localparam int LED_ON_50MS  = 5000000;
  localparam int LED_OFF_50MS = 5000000;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ON   = ST_ON,
    S_OFF  = ST_OFF
  } led_state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pulse_drv_edge_det.sv
// ============================================================================
// evt_edge_det: optional 2-flop input synchronizer (LED_PULSE_SYNC_IN_EN)
// followed by a rising-edge detector producing a one-cycle strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module evt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_evt,
  output logic o_edge
);

  logic w_evt;
  logic r_prev;

`ifdef LED_PULSE_SYNC_IN_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_evt};
    end
  end

  assign w_evt = r_sync[1];
`else
  assign w_evt = i_evt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_evt;
    end
  end

  assign o_edge = w_evt & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/led_pulse_drv.sv
// ============================================================================
// led_pulse_drv: counts event rising edges and plays one LED blink per event
// with minimum on/off times. Optional input synchronizer: LED_PULSE_SYNC_IN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_pulse_drv
  import led_drv_pkg::*;
#(
  parameter int ON_CYCLES  = LED_ON_50MS,
  parameter int OFF_CYCLES = LED_OFF_50MS,
  parameter int CNT_W      = 8
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             evt_in,
  output logic             LED_Out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int TMR_W = $clog2(max_i(ON_CYCLES, OFF_CYCLES) + 1);

  localparam logic [TMR_W-1:0] c_ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] c_PEND_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_PEND_MAX = '1;

  led_state_e       r_state, w_nxt_state;
  logic [TMR_W-1:0] r_timer, w_nxt_timer;
  logic             w_nxt_led;
  logic             w_start;
  logic             w_edge;

  evt_edge_det u_edge_det (
    .clk    (clk_100MHz),
    .rst_n  (rst_n),
    .i_evt  (evt_in),
    .o_edge (w_edge)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_nxt_led   = LED_Out;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pending != '0) w_start = 1'b1;
      end
      S_ON: begin
        if (r_timer != '0) begin
          w_nxt_timer = r_timer - c_TMR_ONE;
        end else begin
          w_nxt_state = S_OFF;
          w_nxt_timer = c_OFF_LOAD;
          w_nxt_led   = 1'b0;
        end
      end
      S_OFF: begin
        if (r_timer != '0) begin
          w_nxt_timer = r_timer - c_TMR_ONE;
        end else if (pending != '0) begin
          w_start = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_timer = '0;
        w_nxt_led   = 1'b0;
      end
    endcase
    // A blink start overrides whatever the state-specific branch chose.
    if (w_start) begin
      w_nxt_state = S_ON;
      w_nxt_timer = c_ON_LOAD;
      w_nxt_led   = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      LED_Out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_timer <= w_nxt_timer;
      LED_Out <= w_nxt_led;
      busy    <= (w_nxt_state != S_IDLE);
    end
  end

  // An edge and a blink start in the same cycle cancel, even when saturated.
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (w_edge && !w_start) begin
      if (pending != c_PEND_MAX) begin
        pending <= pending + c_PEND_ONE;
      end else begin
        overflow <= 1'b1;
      end
    end else if (!w_edge && w_start) begin
      pending <= pending - c_PEND_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pulse_drv.sv
// ============================================================================
// tb_led_pulse_drv: directed self-checking bench for led_pulse_drv
// (ON_CYCLES=4, OFF_CYCLES=3, CNT_W=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_pulse_drv;

`ifdef LED_PULSE_SYNC_IN_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk_100MHz = 1'b0;
  logic       rst_n      = 1'b0;
  logic       evt_in     = 1'b0;
  logic       LED_Out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  led_pulse_drv #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .CNT_W      (2)
  ) u_dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .evt_in     (evt_in),
    .LED_Out    (LED_Out),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    evt_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int r;
    int rises;
    int max_pend;
    logic prev_led;

    // Reset state
    do_reset();
    chk("rst_led", LED_Out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovf", overflow, 0);

    // Single pulse at edge 10
    for (int c = 1; c <= 20 + L; c++) begin
      evt_in = (c == 10);
      tick();
      r = c - L;
      case (r)
        10: chk("t1_pend10", pending, 1);
        11: begin chk("t1_led11", LED_Out, 1); chk("t1_busy11", busy, 1); chk("t1_pend11", pending, 0); end
        14: chk("t1_led14", LED_Out, 1);
        15: begin chk("t1_led15", LED_Out, 0); chk("t1_busy15", busy, 1); end
        17: begin chk("t1_led17", LED_Out, 0); chk("t1_busy17", busy, 1); end
        18: chk("t1_busy18", busy, 0);
        default: ;
      endcase
    end

    // Three pulses at 10,12,14: back-to-back blinks
    do_reset();
    for (int c = 1; c <= 34 + L; c++) begin
      evt_in = (c == 10 || c == 12 || c == 14);
      tick();
      r = c - L;
      case (r)
        10: chk("t2_pend10", pending, 1);
        11: chk("t2_pend11", pending, 0);
        12: chk("t2_pend12", pending, 1);
        13: chk("t2_pend13", pending, 1);
        14: chk("t2_pend14", pending, 2);
        17: chk("t2_led17", LED_Out, 0);
        18: begin chk("t2_led18", LED_Out, 1); chk("t2_busy18", busy, 1); chk("t2_pend18", pending, 1); end
        24: chk("t2_led24", LED_Out, 0);
        25: begin chk("t2_led25", LED_Out, 1); chk("t2_pend25", pending, 0); end
        31: chk("t2_busy31", busy, 1);
        32: begin chk("t2_busy32", busy, 0); chk("t2_ovf32", overflow, 0); end
        default: ;
      endcase
    end

    // Level held high for 20 cycles: one blink only
    do_reset();
    rises    = 0;
    max_pend = 0;
    prev_led = 1'b0;
    for (int c = 1; c <= 40 + L; c++) begin
      evt_in = (c >= 10 && c < 30);
      tick();
      if (LED_Out && !prev_led) rises++;
      prev_led = LED_Out;
      if (int'(pending) > max_pend) max_pend = int'(pending);
    end
    chk("t3_blinks", rises, 1);
    chk("t3_maxpend", max_pend, 1);
    chk("t3_busy_end", busy, 0);

    // Edge coinciding with OFF->ON restart
    do_reset();
    for (int c = 1; c <= 27 + L; c++) begin
      evt_in = (c == 10 || c == 12 || c == 18);
      tick();
      r = c - L;
      case (r)
        12: chk("t5_pend12", pending, 1);
        17: chk("t5_pend17", pending, 1);
        18: begin chk("t5_pend18", pending, 1); chk("t5_led18", LED_Out, 1); end
        25: begin chk("t5_pend25", pending, 0); chk("t5_led25", LED_Out, 1); end
        default: ;
      endcase
    end

    // Five edges while busy: saturation and sticky overflow
    do_reset();
    rises    = 0;
    prev_led = 1'b0;
    for (int c = 1; c <= 48 + L; c++) begin
      evt_in = (c == 10 || c == 12 || c == 14 || c == 16 || c == 18 || c == 20);
      tick();
      if (LED_Out && !prev_led) rises++;
      prev_led = LED_Out;
      r = c - L;
      case (r)
        16: begin chk("t4_pend16", pending, 3); chk("t4_ovf16", overflow, 0); end
        18: begin chk("t4_pend18", pending, 3); chk("t4_ovf18", overflow, 0); end
        20: begin chk("t4_pend20", pending, 3); chk("t4_ovf20", overflow, 1); end
        25: chk("t4_pend25", pending, 2);
        32: chk("t4_pend32", pending, 1);
        39: begin chk("t4_pend39", pending, 0); chk("t4_led39", LED_Out, 1); end
        46: begin chk("t4_busy46", busy, 0); chk("t4_ovf46", overflow, 1); end
        default: ;
      endcase
    end
    chk("t4_blinks", rises, 5);

    // Reset during ON (continues from saturated/overflow state), then clean restart
    cyc = 0;
    for (int c = 1; c <= 16 + 2 * L; c++) begin
      evt_in = (c == 10 || c == 12 || c >= 14 + L);
      rst_n  = (c != 13 + L);
      tick();
      if (c == 12 + L) begin
        chk("t6_pend12", pending, 1);
        chk("t6_ovf12", overflow, 1);
        chk("t6_led12", LED_Out, 1);
      end
      if (c == 13 + L) begin
        chk("t6_rst_led", LED_Out, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_ovf", overflow, 0);
      end
      if (c == 14 + 2 * L) begin
        chk("t6_pend_new", pending, 1);
        chk("t6_led_new0", LED_Out, 0);
      end
      if (c == 15 + 2 * L) begin
        chk("t6_led_new1", LED_Out, 1);
        chk("t6_busy_new", busy, 1);
        chk("t6_pend_new1", pending, 0);
      end
    end
    rst_n  = 1'b1;
    evt_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
